// File: rtl/btn_defs.sv
// Shared button-handling definitions: channel FSM state encodings and default timing.
// The movement-control blocks import this package too.
package btn_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One pushbutton: 2-FF synchroniser, debounce filter and press/auto-repeat strobe FSM.
// BTN_AUTO_REPEAT_EN selects the full IDLE/DELAY/REPEAT FSM; otherwise press-edge only.
module btn_channel
  import btn_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb,
  output logic strobe
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic [DW-1:0] deb_cnt;
  btn_state_t    state, state_nx;
  logic          strobe_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // deb only follows s2 after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else if (s2 == deb) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      deb     <= s2;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int TW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  logic [TW-1:0] timer, timer_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      timer  <= '0;
      strobe <= 1'b0;
    end else begin
      state  <= state_nx;
      timer  <= timer_nx;
      strobe <= strobe_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    strobe_nx = 1'b0;
    if (!deb) begin
      state_nx = IDLE;
      timer_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          strobe_nx = 1'b1;
          timer_nx  = '0;
          state_nx  = DELAY;
        end
        DELAY: begin
          if (timer == DELAY_LAST) begin
            strobe_nx = 1'b1;
            timer_nx  = '0;
            state_nx  = REPEAT;
          end else begin
            timer_nx = timer + 1'b1;
          end
        end
        REPEAT: begin
          if (timer == PERIOD_LAST) begin
            strobe_nx = 1'b1;
            timer_nx  = '0;
          end else begin
            timer_nx = timer + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          timer_nx = '0;
        end
      endcase
    end
  end
`else
  // Repeat timing has no effect here; the parameters stay for a uniform interface.
  logic unused_params;
  assign unused_params = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      strobe <= 1'b0;
    end else begin
      state  <= state_nx;
      strobe <= strobe_nx;
    end
  end

  // DELAY just means "held, strobe already sent" until the button is released
  always_comb begin
    state_nx  = state;
    strobe_nx = 1'b0;
    if (!deb) begin
      state_nx = IDLE;
    end else if (state == IDLE) begin
      strobe_nx = 1'b1;
      state_nx  = DELAY;
    end
  end
`endif

endmodule

// File: rtl/button_conditioner.sv
// Right/left pushbutton conditioner producing one-cycle move strobes pbR/pbL.
// Auto-repeat is built only when BTN_AUTO_REPEAT_EN is defined.
module button_conditioner
  import btn_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btnR_raw,
  input  logic btnL_raw,
  output logic pbR,
  output logic pbL
);

  logic deb_r, deb_l, stb_r, stb_l, conflict;

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_right (
    .clk   (clk),
    .reset (reset),
    .raw   (btnR_raw),
    .deb   (deb_r),
    .strobe(stb_r)
  );

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_left (
    .clk   (clk),
    .reset (reset),
    .raw   (btnL_raw),
    .deb   (deb_l),
    .strobe(stb_l)
  );

  // Both directions held: suppress moves, but channel timers keep running
  assign conflict = deb_r & deb_l;
  assign pbR      = stb_r & ~conflict;
  assign pbL      = stb_l & ~conflict;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: segment table, directed corner sequences, random vs. reference model.
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, btnR_raw, btnL_raw;
  logic pbR, pbL;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btnR_raw(btnR_raw),
    .btnL_raw(btnL_raw),
    .pbR     (pbR),
    .pbL     (pbL)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model: deb flips once the last D synced samples all disagree with it;
  // strobes fall at press time T, T+RD, T+RD+k*RP while deb stays high.
  bit m_s1[2], m_s2[2], m_deb[2], m_stb[2];
  bit m_hist[2][$];
  int m_held[2] = '{-1, -1};
  int m_n = 0;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_deb[c] = 0; m_stb[c] = 0;
      m_hist[c].delete();
      m_held[c] = -1;
    end
    m_n = 0;
  endtask

  task automatic model_step();
    bit raw[2];
    bit os2, odeb, all_diff;
    int k;
    raw[0] = btnR_raw;
    raw[1] = btnL_raw;
    m_n++;
    for (int c = 0; c < 2; c++) begin
      os2  = m_s2[c];
      odeb = m_deb[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = raw[c];
      m_hist[c].push_back(os2);
      if (m_hist[c].size() > D) void'(m_hist[c].pop_front());
      all_diff = (m_hist[c].size() == D);
      foreach (m_hist[c][i]) if (m_hist[c][i] == odeb) all_diff = 0;
      if (all_diff) m_deb[c] = os2;
      m_stb[c] = 0;
      if (!odeb) m_held[c] = -1;
      else if (m_held[c] < 0) begin
        m_held[c] = m_n;
        m_stb[c]  = 1;
      end else if (AUTO) begin
        k = m_n - m_held[c];
        m_stb[c] = (k == RD) || (k > RD && ((k - RD) % RP) == 0);
      end
    end
  endtask

  always begin
    @(posedge clk or posedge reset);
    if (reset) model_reset();
    else model_step();
  end

  bit mon_en = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("model_pbR", pbR, int'(m_stb[0] & ~(m_deb[0] & m_deb[1])));
      check("model_pbL", pbL, int'(m_stb[1] & ~(m_deb[0] & m_deb[1])));
    end
  end

  typedef struct {
    bit r;
    bit l;
    int len;
    int exp_r;
    int exp_l;
  } seg_t;

  seg_t segs[14];
  int   got[$];
  int   exp_q[$];

  initial begin
    int cr, cl, win, first_l;

    segs[0]  = '{0, 0, 12, 0, 0};
    segs[1]  = '{1, 0, 3,  0, 0};                  // tap shorter than D
    segs[2]  = '{0, 0, 12, 0, 0};
    segs[3]  = '{1, 0, 4,  0, 0};                  // tap of exactly D
    segs[4]  = '{0, 0, 12, 1, 0};
    segs[5]  = '{1, 0, 9,  1, 0};
    segs[6]  = '{0, 0, 12, 0, 0};
    segs[7]  = '{1, 0, 40, AUTO ? 6 : 1, 0};
    segs[8]  = '{0, 0, 12, AUTO ? 1 : 0, 0};
    segs[9]  = '{0, 1, 9,  0, 1};
    segs[10] = '{0, 0, 12, 0, 0};
    segs[11] = '{1, 1, 20, 0, 0};                  // simultaneous press: conflict
    segs[12] = '{0, 1, 20, 0, AUTO ? 3 : 0};
    segs[13] = '{0, 0, 12, 0, AUTO ? 1 : 0};

    reset = 1'b1; btnR_raw = 1'b0; btnL_raw = 1'b0;
    repeat (2) tick();
    check("reset_pbR", pbR, 0);
    check("reset_pbL", pbL, 0);
    reset = 1'b0;
    mon_en = 1;

    foreach (segs[i]) begin
      btnR_raw = segs[i].r;
      btnL_raw = segs[i].l;
      cr = 0; cl = 0;
      for (int c = 0; c < segs[i].len; c++) begin
        tick();
        cr += int'(pbR);
        cl += int'(pbL);
      end
      check($sformatf("seg%0d_pbR_count", i), cr, segs[i].exp_r);
      check($sformatf("seg%0d_pbL_count", i), cl, segs[i].exp_l);
    end

    // reset while held, asserted mid-cycle
    btnR_raw = 1'b1;
    repeat (7) tick();
    check("press_pbR_before_reset", pbR, 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_pbR", pbR, 0);
    check("async_reset_pbL", pbL, 0);
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      check($sformatf("post_reset_pbR_c%0d", c), pbR, int'(c == 7));
    end
    btnR_raw = 1'b0;
    repeat (12) tick();

    // bounce then hold
    cr = 0;
    for (int c = 0; c < 8; c++) begin
      btnR_raw = ((c / 2) % 2 == 0);
      tick();
      cr += int'(pbR);
    end
    check("bounce_no_pbR", cr, 0);
    btnR_raw = 1'b1;
    first_l = -1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (pbR && first_l < 0) first_l = c;
    end
    check("bounce_first_pbR_cycle", first_l, 7);
    btnR_raw = 1'b0;
    repeat (12) tick();

    // auto-repeat timing on L
    got.delete();
    exp_q.delete();
    exp_q.push_back(7);
    if (AUTO) for (int t = 7 + RD; t <= 42; t += RP) exp_q.push_back(t);
    btnL_raw = 1'b1;
    for (int c = 1; c <= 55; c++) begin
      if (c == 41) btnL_raw = 1'b0;
      tick();
      if (pbL) got.push_back(c);
    end
    check("repeat_pulse_count", got.size(), exp_q.size());
    foreach (exp_q[i])
      check($sformatf("repeat_pulse%0d_cycle", i), (i < got.size()) ? got[i] : -1, exp_q[i]);

    // conflict: R held, L joins, R released
    btnR_raw = 1'b1;
    repeat (20) tick();
    btnL_raw = 1'b1;
    win = 0; first_l = -1;
    for (int c = 1; c <= 60; c++) begin
      if (c == 31) btnR_raw = 1'b0;
      tick();
      if (c >= 6 && c <= 36) win += int'(pbR) + int'(pbL);
      else if (c > 36 && pbL && first_l < 0) first_l = c;
    end
    check("conflict_window_pulses", win, 0);
    check("conflict_first_l_after", first_l, AUTO ? 37 : -1);
    btnL_raw = 1'b0;
    repeat (12) tick();

    // random stimulus, monitored against the model every cycle
    repeat (60) begin
      btnR_raw = 1'($urandom_range(0, 1));
      btnL_raw = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 30)) tick();
      if ($urandom_range(0, 9) == 0) begin
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
      end
    end

    mon_en = 0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
